// File: rtl/seven_seg_reader.sv
// Recovers the value shown on a multiplexed 8-digit seven-segment display by
// sampling its anode/cathode lines, capturing each digit after it has settled.
module seven_seg_reader #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  output logic [31:0] number,
  output logic        number_valid,
  output logic        frame_error,
  output logic [7:0]  digit_seen
);

  logic [7:0]  prev_anode;
  logic [6:0]  prev_cathode;
  logic [3:0]  cnt;
  logic [31:0] shadow;
  logic [7:0]  seen;
  logic        err_acc;

  logic        one_hot;
  logic        match;
  logic        capture;
  logic [2:0]  digit_idx;
  logic [6:0]  pattern;
  logic [3:0]  nibble;
  logic        dec_err;
  logic [31:0] shadow_next;
  logic [7:0]  seen_next;

  // A digit only counts when exactly one anode is driven low and the whole
  // input word repeats the previous cycle.
  always_comb begin
    one_hot   = ($countones(~anode) == 1);
    match     = one_hot && ({anode, cathode} == {prev_anode, prev_cathode});
    capture   = match && (cnt == 4'(SETTLE - 1));
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!anode[i]) digit_idx = 3'(i);
    end
  end

  // Cathodes are active-low, so decode the inverted gfedcba pattern.
  always_comb begin
    pattern = ~cathode;
    nibble  = 4'h0;
    dec_err = 1'b0;
    case (pattern)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      7'h00: nibble = 4'h0;
      default: begin
        nibble  = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    shadow_next = shadow;
    shadow_next[4*digit_idx +: 4] = nibble;
    seen_next = seen | (8'd1 << digit_idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_anode   <= '0;
      prev_cathode <= '0;
      cnt          <= '0;
      shadow       <= '0;
      seen         <= '0;
      err_acc      <= 1'b0;
      number       <= '0;
      number_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      prev_anode   <= anode;
      prev_cathode <= cathode;
      number_valid <= 1'b0;
      if (!match) begin
        cnt <= '0;
      end else if (cnt < 4'(SETTLE)) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        shadow <= shadow_next;
        // The capture that fills the last missing digit publishes the frame.
        if (seen_next == 8'hFF) begin
          number       <= shadow_next;
          number_valid <= 1'b1;
          frame_error  <= err_acc | dec_err;
          seen         <= '0;
          err_acc      <= 1'b0;
        end else begin
          seen    <= seen_next;
          err_acc <= err_acc | dec_err;
        end
      end
    end
  end

  assign digit_seen = seen;

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: SETTLE, 2, number of repeat cycles a digit must hold before it is captured; legal range is 1 to 15.
REQ-002 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: anode  in  8  active-low digit enables; anode[i]=0 selects digit i; digit 7 is the most significant nibble.
REQ-005 Port: cathode  in  7  active-low segments; cathode[0]=a ... cathode[6]=g; 0 means the segment is lit.
REQ-006 Port: number  out  32  last completely captured value; digit i maps to number[4i+3:4i].
REQ-007 Port: number_valid  out  1  one-cycle pulse when number is loaded.
REQ-008 Port: frame_error  out  1  the last completed frame contained an undecodable digit.
REQ-009 Port: digit_seen  out  8  digits captured so far in the current frame.

Function
REQ-010 One-hot check: the block SHALL treat {anode,cathode} as one-hot only when exactly one anode bit is 0.
REQ-011 Idle and illegal inputs: all-ones anode, and anode with two or more low bits, SHALL never cause a capture.
REQ-012 History: the block SHALL register the previous cycle's {anode,cathode} as prev.
- match = one-hot AND current {anode,cathode} equals prev.
REQ-013 Stable counter cnt (4 bits) SHALL follow these rules:
- !match -> cnt := 0.
- match and cnt < SETTLE -> cnt := cnt+1.
- Otherwise cnt holds (saturates at SETTLE).
REQ-014 Capture timing: a capture SHALL occur on the edge where match is true and cnt == SETTLE-1.
- Inputs must therefore be constant for SETTLE+1 consecutive cycles.
- Exactly one capture occurs per uninterrupted dwell.
REQ-015 Decode: a capture SHALL write the decoded nibble into shadow[4i+3:4i] and set seen[i].
- Active-high gfedcba patterns, so cathode = ~pattern.
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-016 Blank digit: a blank digit (cathode 7'h7F) SHALL decode to nibble 0 without error.
REQ-017 Undecodable patterns: any other pattern SHALL decode to nibble 0 and set the internal err_acc flag.
REQ-018 Re-capture: re-capturing a digit already marked in seen SHALL overwrite its nibble (latest wins) and SHALL NOT complete the frame by itself.
REQ-019 Frame completion: on the edge where a capture makes (seen | capture bit) == 8'hFF, the block SHALL do all of the following on that same edge:
- Load number with the updated shadow.
- Assert number_valid for exactly the following cycle.
- Load frame_error with (err_acc OR the current decode error).
- Clear seen and err_acc.
REQ-020 Output hold: number and frame_error SHALL hold their values between completions.
- number_valid SHALL be 0 in every other cycle.
REQ-021 Digit order: the block SHALL accept digits in any scan order and any dwell length of at least SETTLE+1 cycles.
REQ-022 digit_seen SHALL equal seen at all times.

Reset
REQ-023 When reset is high at a clock edge, the block SHALL clear the following:
- Outputs: number=0, number_valid=0, frame_error=0, digit_seen=0.
- Internal state: prev, cnt, shadow and err_acc.
REQ-024 Reset SHALL take priority over a simultaneous capture or completion, and the partial frame SHALL be discarded.
REQ-025 After reset is released, the first capture SHALL require a fresh SETTLE+1 cycle dwell.

Verification
REQ-026 Normal frame: scan 0x12345678 over digits 0..7, 4 cycles each, SETTLE=2 -> the bench SHALL check the following:
- Exactly one number_valid pulse.
- number=0x12345678 and frame_error=0.
REQ-027 Short dwell: hold digit 2 for only 2 cycles, then scan all 8 digits normally -> the bench SHALL check the following:
- digit_seen[2] stays 0 during the short dwell.
- Completion occurs only after digit 2 is properly held.
REQ-028 Illegal and idle anodes: hold anode=8'hFC for 10 cycles, then 8'hFF for 10 cycles -> the bench SHALL check that digit_seen stays 0 and no pulse occurs.
REQ-029 Bad segment pattern: drive digit 5 with cathode=7'h7E (segment a only) within a full scan -> the bench SHALL check the following:
- number_valid pulses with number[23:20]=0.
- frame_error=1.
- frame_error returns to 0 after the next clean frame.
REQ-030 Reset mid-frame: assert reset after 5 digits are captured, then run a full scan of 0xDEADBEEF -> the bench SHALL check the following:
- digit_seen=0 after reset.
- number=0xDEADBEEF with no stale nibbles.
REQ-031 Overwrite: scan digit 3 as 4, then digit 3 again as 9, then the remaining digits -> the bench SHALL check that number[15:12]=9 with a single pulse.
